// File: rtl/sound_pkg.sv
// Shared definitions for the sound event sequencer: tone table, state
// encoding and a small priority helper.
package sound_pkg;

    // Sequencer states: waiting, sounding a note, enforced silence after a note.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Tone generator prescaler values for a 31.5 MHz clock, lowest note first.
    localparam logic [9:0] TONE_TABLE [16] = '{
        10'h1D6, 10'h1BC, 10'h1A3, 10'h18B,
        10'h175, 10'h160, 10'h14D, 10'h13A,
        10'h128, 10'h118, 10'h108, 10'h0F9,
        10'h0EB, 10'h0DD, 10'h0D1, 10'h0C5
    };

    // Value parked on the prescaler output whenever nothing is sounding.
    localparam logic [9:0] TONE_REST = TONE_TABLE[0];

    // Index of the lowest set bit (bit 0 wins); 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sound_timer.sv
// Loadable down-counter used for both note length and inter-note silence.
// Decrement saturates at zero so the count can never wrap.
module sound_timer
    import sound_pkg::*;
#(
    parameter int DUR_W = 24
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic [DUR_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [DUR_W-1:0] count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - DUR_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sound_event_sequencer.sv
// Sound event sequencer: collects event requests into a sticky pending set,
// plays them one note at a time in priority order (bit 0 highest), optionally
// inserts silence between notes and optionally lets a higher-priority request
// cut the current note short. All outputs are registered.
module sound_event_sequencer
    import sound_pkg::*;
#(
    parameter int               NUM_EVENTS = 4,
    parameter int               DUR_W      = 24,
    parameter logic [3:0]       EVENT_TONE [NUM_EVENTS] = '{4'd2, 4'd3, 4'd6, 4'd0},
    parameter logic [DUR_W-1:0] EVENT_DUR  [NUM_EVENTS] = '{24'd3_150_000, 24'd3_150_000,
                                                            24'd1_575_000, 24'd6_300_000},
    parameter int               GAP_CYCLES = 0,
    parameter bit               PREEMPT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_EVENTS-1:0] event_req,
    output logic [9:0]            preScaleValue,
    output logic                  enabler,
    output logic [2:0]            active_event,
    output logic                  busy
);

    localparam int IDX_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    // Timer reload for the silence phase; the load value is count-1 so the
    // phase lasts exactly GAP_CYCLES cycles.
    localparam logic [DUR_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? DUR_W'(GAP_CYCLES - 1) : '0;

    state_t                state;
    logic [NUM_EVENTS-1:0] pending;
    logic [NUM_EVENTS-1:0] req_all;
    logic [NUM_EVENTS-1:0] grant_onehot;
    logic [NUM_EVENTS-1:0] lower_mask;
    logic [NUM_EVENTS-1:0] clear_mask;
    logic [2:0]            grant_idx;
    logic [IDX_W-1:0]      grant_sel;
    logic                  any_req;
    logic                  preempt_hit;
    logic                  do_grant;
    logic                  to_gap;
    logic                  to_idle;
    logic                  timer_load;
    logic                  timer_dec;
    logic                  timer_zero;
    logic [DUR_W-1:0]      timer_value;

    // Arbitration: merge new requests with the sticky set and pick the winner.
    always_comb begin
        req_all      = pending | event_req;
        any_req      = |req_all;
        grant_idx    = lowest_set(8'(req_all));
        grant_sel    = grant_idx[IDX_W-1:0];
        grant_onehot = '0;
        lower_mask   = '0;
        for (int k = 0; k < NUM_EVENTS; k++) begin
            grant_onehot[k] = (grant_idx == 3'(k));
            lower_mask[k]   = (k < int'(active_event));
        end
        // Only fresh requests above the playing note's priority may cut it.
        preempt_hit = PREEMPT && (state == ST_PLAY) && (|(event_req & lower_mask));
    end

    // Next-step decision: start a note, enter the silence phase, or go idle.
    always_comb begin
        do_grant = 1'b0;
        to_gap   = 1'b0;
        to_idle  = 1'b0;
        case (state)
            ST_IDLE: begin
                do_grant = any_req;
            end
            ST_PLAY: begin
                if (preempt_hit) begin
                    do_grant = 1'b1;
                end else if (timer_zero) begin
                    if (GAP_CYCLES > 0) begin
                        to_gap = 1'b1;
                    end else if (any_req) begin
                        do_grant = 1'b1;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (timer_zero) begin
                    if (any_req) begin
                        do_grant = 1'b1;
                    end else begin
                        to_idle = 1'b1;
                    end
                end
            end
            default: begin
                to_idle = 1'b1;
            end
        endcase
        clear_mask  = do_grant ? grant_onehot : '0;
        timer_load  = do_grant || to_gap;
        timer_value = do_grant ? (EVENT_DUR[grant_sel] - DUR_W'(1)) : GAP_LOAD;
        timer_dec   = (state != ST_IDLE) && !timer_load;
    end

    sound_timer #(
        .DUR_W (DUR_W)
    ) u_timer (
        .clk        (clk),
        .resetN     (resetN),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .zero       (timer_zero)
    );

    // State, pending set and all outputs; an aborted note is simply replaced.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= ST_IDLE;
            pending       <= '0;
            enabler       <= 1'b0;
            busy          <= 1'b0;
            active_event  <= 3'd0;
            preScaleValue <= TONE_REST;
        end else begin
            pending <= req_all & ~clear_mask;
            if (do_grant) begin
                state         <= ST_PLAY;
                enabler       <= 1'b1;
                busy          <= 1'b1;
                active_event  <= grant_idx;
                preScaleValue <= TONE_TABLE[EVENT_TONE[grant_sel]];
            end else if (to_gap) begin
                state         <= ST_GAP;
                enabler       <= 1'b0;
                busy          <= 1'b1;
                preScaleValue <= TONE_REST;
            end else if (to_idle) begin
                state         <= ST_IDLE;
                enabler       <= 1'b0;
                busy          <= 1'b0;
                preScaleValue <= TONE_REST;
            end
        end
    end

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: two instances (preempting and
// non-preempting) driven with directed scenarios and random requests.
module tb_sound_event_sequencer;

    localparam int NE  = 3;
    localparam int DW  = 24;
    localparam int GAP = 2;
    localparam logic [3:0]    TONE_IDX [NE] = '{4'd2, 4'd3, 4'd6};
    localparam logic [DW-1:0] DUR      [NE] = '{24'd4, 24'd8, 24'd6};
    localparam logic [9:0]    TT [16] = '{
        10'h1D6, 10'h1BC, 10'h1A3, 10'h18B, 10'h175, 10'h160, 10'h14D, 10'h13A,
        10'h128, 10'h118, 10'h108, 10'h0F9, 10'h0EB, 10'h0DD, 10'h0D1, 10'h0C5
    };

    // clock / reset
    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    logic [2:0] req_a, req_b;
    logic [9:0] ps_a, ps_b;
    logic       en_a, en_b, busy_a, busy_b;
    logic [2:0] act_a, act_b;

    int n_checks = 0;
    int n_fail   = 0;

    sound_event_sequencer #(
        .NUM_EVENTS (NE), .DUR_W (DW), .EVENT_TONE (TONE_IDX), .EVENT_DUR (DUR),
        .GAP_CYCLES (GAP), .PREEMPT (1'b1)
    ) dut_a (
        .clk (clk), .resetN (resetN), .event_req (req_a),
        .preScaleValue (ps_a), .enabler (en_a), .active_event (act_a), .busy (busy_a)
    );

    sound_event_sequencer #(
        .NUM_EVENTS (NE), .DUR_W (DW), .EVENT_TONE (TONE_IDX), .EVENT_DUR (DUR),
        .GAP_CYCLES (GAP), .PREEMPT (1'b0)
    ) dut_b (
        .clk (clk), .resetN (resetN), .event_req (req_b),
        .preScaleValue (ps_b), .enabler (en_b), .active_event (act_b), .busy (busy_b)
    );

    // Observation vector; active_event only matters while a note sounds.
    function automatic logic [14:0] obs(input logic en, input logic bsy,
                                        input logic [9:0] ps, input logic [2:0] act);
        return {en, bsy, ps, (en ? act : 3'd0)};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        req_a  = 3'd0;
        req_b  = 3'd0;
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    // Reference model: notes measured in remaining cycles, pending as a set.
    int         m_play [2];
    int         m_gap  [2];
    int         m_act  [2];
    logic [2:0] m_pend [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_play[k] = 0;
            m_gap[k]  = 0;
            m_act[k]  = 0;
            m_pend[k] = 3'd0;
        end
    endtask

    task automatic model_start(input int k, input logic [2:0] all, input int j);
        logic [2:0] one;
        one       = 3'b001 << j;
        m_play[k] = int'(DUR[j]);
        m_gap[k]  = 0;
        m_act[k]  = j;
        m_pend[k] = all & ~one;
    endtask

    task automatic model_step(input int k, input logic [2:0] req);
        logic [2:0] all;
        int         j;
        bit         higher;
        all    = m_pend[k] | req;
        j      = -1;
        higher = 1'b0;
        for (int b = NE - 1; b >= 0; b--) if (all[b]) j = b;
        for (int b = 0; b < NE; b++) if (b < m_act[k] && req[b]) higher = 1'b1;
        if (m_play[k] > 0) begin
            if (k == 0 && higher) begin
                model_start(k, all, j);
            end else if (m_play[k] == 1) begin
                m_play[k] = 0;
                m_gap[k]  = GAP;
                m_pend[k] = all;
            end else begin
                m_play[k] = m_play[k] - 1;
                m_pend[k] = all;
            end
        end else if (m_gap[k] > 0) begin
            if (m_gap[k] == 1) begin
                if (j >= 0) model_start(k, all, j);
                else begin
                    m_gap[k]  = 0;
                    m_pend[k] = all;
                end
            end else begin
                m_gap[k]  = m_gap[k] - 1;
                m_pend[k] = all;
            end
        end else if (j >= 0) begin
            model_start(k, all, j);
        end else begin
            m_pend[k] = all;
        end
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        req_a  = 3'd0;
        req_b  = 3'd0;
        resetN = 1'b0;
        tick();
        exp_v = obs(1'b0, 1'b0, 10'h1D6, 3'd0);
        n_checks++;
        if ({en_a, busy_a, ps_a, act_a} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_a got=%h exp=%h", {en_a, busy_a, ps_a, act_a}, exp_v);
        end
        n_checks++;
        if ({en_b, busy_b, ps_b, act_b} !== exp_v) begin
            n_fail++;
            $display("FAIL reset_b got=%h exp=%h", {en_b, busy_b, ps_b, act_b}, exp_v);
        end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_single_note();
        logic [14:0] exp_v;
        apply_reset();
        req_a = 3'b010;
        req_b = 3'b010;
        tick();
        req_a = 3'd0;
        req_b = 3'd0;
        for (int t = 0; t < 12; t++) begin
            exp_v = obs(t < 8, t < 10, (t < 8) ? 10'h18B : 10'h1D6, 3'd1);
            n_checks++;
            if (obs(en_a, busy_a, ps_a, act_a) !== exp_v) begin
                n_fail++;
                $display("FAIL single_a t=%0d got=%h exp=%h", t, obs(en_a, busy_a, ps_a, act_a), exp_v);
            end
            n_checks++;
            if (obs(en_b, busy_b, ps_b, act_b) !== exp_v) begin
                n_fail++;
                $display("FAIL single_b t=%0d got=%h exp=%h", t, obs(en_b, busy_b, ps_b, act_b), exp_v);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_v;
        logic        e;
        apply_reset();
        req_a = 3'b110;
        req_b = 3'b110;
        tick();
        req_a = 3'd0;
        req_b = 3'd0;
        for (int t = 0; t < 20; t++) begin
            e     = (t < 8) || (t >= 10 && t < 16);
            exp_v = obs(e, t < 18, (t < 8) ? 10'h18B : (e ? 10'h14D : 10'h1D6),
                        (t < 8) ? 3'd1 : 3'd2);
            n_checks++;
            if (obs(en_a, busy_a, ps_a, act_a) !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_a t=%0d got=%h exp=%h", t, obs(en_a, busy_a, ps_a, act_a), exp_v);
            end
            n_checks++;
            if (obs(en_b, busy_b, ps_b, act_b) !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_b t=%0d got=%h exp=%h", t, obs(en_b, busy_b, ps_b, act_b), exp_v);
            end
            tick();
        end
    endtask

    task automatic test_preempt();
        logic [14:0] exp_a, exp_b;
        logic        e;
        apply_reset();
        req_a = 3'b100;
        req_b = 3'b100;
        tick();
        for (int t = 0; t < 16; t++) begin
            e     = (t <= 6);
            exp_a = obs(e, t <= 8, (t <= 2) ? 10'h14D : (e ? 10'h1A3 : 10'h1D6),
                        (t <= 2) ? 3'd2 : 3'd0);
            e     = (t <= 5) || (t >= 8 && t <= 11);
            exp_b = obs(e, t <= 13, (t <= 5) ? 10'h14D : (e ? 10'h1A3 : 10'h1D6),
                        (t <= 5) ? 3'd2 : 3'd0);
            n_checks++;
            if (obs(en_a, busy_a, ps_a, act_a) !== exp_a) begin
                n_fail++;
                $display("FAIL preempt_on t=%0d got=%h exp=%h", t, obs(en_a, busy_a, ps_a, act_a), exp_a);
            end
            n_checks++;
            if (obs(en_b, busy_b, ps_b, act_b) !== exp_b) begin
                n_fail++;
                $display("FAIL preempt_off t=%0d got=%h exp=%h", t, obs(en_b, busy_b, ps_b, act_b), exp_b);
            end
            req_a = (t == 2) ? 3'b001 : 3'b000;
            req_b = req_a;
            tick();
        end
    endtask

    task automatic test_reset_mid_note();
        logic [14:0] exp_v;
        apply_reset();
        req_a = 3'b010;
        req_b = 3'b010;
        tick();
        req_a = 3'd0;
        req_b = 3'd0;
        tick();
        req_a = 3'b100;
        req_b = 3'b100;
        tick();
        req_a = 3'd0;
        req_b = 3'd0;
        tick();
        #1 resetN = 1'b0;
        #1;
        exp_v = obs(1'b0, 1'b0, 10'h1D6, 3'd0);
        n_checks++;
        if ({en_a, busy_a, ps_a, act_a} !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset_a got=%h exp=%h", {en_a, busy_a, ps_a, act_a}, exp_v);
        end
        n_checks++;
        if ({en_b, busy_b, ps_b, act_b} !== exp_v) begin
            n_fail++;
            $display("FAIL async_reset_b got=%h exp=%h", {en_b, busy_b, ps_b, act_b}, exp_v);
        end
        #1 resetN = 1'b1;
        tick();
        for (int t = 0; t < 14; t++) begin
            n_checks++;
            if (obs(en_a, busy_a, ps_a, act_a) !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_a t=%0d got=%h exp=%h", t, obs(en_a, busy_a, ps_a, act_a), exp_v);
            end
            n_checks++;
            if (obs(en_b, busy_b, ps_b, act_b) !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset_b t=%0d got=%h exp=%h", t, obs(en_b, busy_b, ps_b, act_b), exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [14:0] exp_v;
        logic        e;
        apply_reset();
        model_reset();
        for (int t = 0; t < 600; t++) begin
            req_a = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            req_b = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            model_step(0, req_a);
            model_step(1, req_b);
            tick();
            e     = (m_play[0] > 0);
            exp_v = obs(e, e || (m_gap[0] > 0), e ? TT[TONE_IDX[m_act[0]]] : TT[0], 3'(m_act[0]));
            n_checks++;
            if (obs(en_a, busy_a, ps_a, act_a) !== exp_v) begin
                n_fail++;
                $display("FAIL random_a t=%0d got=%h exp=%h", t, obs(en_a, busy_a, ps_a, act_a), exp_v);
            end
            e     = (m_play[1] > 0);
            exp_v = obs(e, e || (m_gap[1] > 0), e ? TT[TONE_IDX[m_act[1]]] : TT[0], 3'(m_act[1]));
            n_checks++;
            if (obs(en_b, busy_b, ps_b, act_b) !== exp_v) begin
                n_fail++;
                $display("FAIL random_b t=%0d got=%h exp=%h", t, obs(en_b, busy_b, ps_b, act_b), exp_v);
            end
        end
        req_a = 3'd0;
        req_b = 3'd0;
    endtask

    initial begin
        resetN = 1'b0;
        req_a  = 3'd0;
        req_b  = 3'd0;
        @(negedge clk);
        test_reset();
        test_single_note();
        test_back_to_back();
        test_preempt();
        test_reset_mid_note();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
